// File: rtl/decode_pkg.sv
// Shared encodings, decoded-bundle type and immediate-extension helper for
// the registered instruction decoder.
package decode_pkg;

  // Opcode field instr[15:12]; immediate forms reuse the register-op ext codes
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_RSHI  = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_SUBCI = 4'b1010;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_LSHI  = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_MULI  = 4'b1110;
  localparam logic [3:0] OP_ARSHI = 4'b1111;

  localparam logic [3:0] EXT_WAIT = 4'b0000;
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_NOT  = 4'b0100;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDU = 4'b0110;
  localparam logic [3:0] EXT_ADDC = 4'b0111;
  localparam logic [3:0] EXT_RSH  = 4'b1000;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_SUBC = 4'b1010;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_LSH  = 4'b1100;
  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_MUL  = 4'b1110;
  localparam logic [3:0] EXT_ARSH = 4'b1111;
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,  ALU_ADD  = 5'd1,  ALU_ADDU = 5'd2,  ALU_ADDC = 5'd3,
    ALU_SUB  = 5'd4,  ALU_SUBC = 5'd5,  ALU_CMP  = 5'd6,  ALU_MUL  = 5'd7,
    ALU_AND  = 5'd8,  ALU_OR   = 5'd9,  ALU_XOR  = 5'd10, ALU_NOT  = 5'd11,
    ALU_MOV  = 5'd12, ALU_LSH  = 5'd13, ALU_RSH  = 5'd14, ALU_ARSH = 5'd15,
    ALU_LOAD = 5'd16, ALU_STOR = 5'd17
  } alu_op_e;

  // wen is kept at the full 4-bit field span; imm is pre-extended to 16 bits
  // and sign-carried, so the top widens it to DATA_W at the output.
  typedef struct packed {
    alu_op_e     alu_op;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [15:0] wen;
    logic [15:0] imm;
    logic        imm_sel;
    logic        flag_en;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
  } dec_bundle_t;

  function automatic alu_op_e alu_of(input logic [3:0] code);
    case (code)
      EXT_AND:  alu_of = ALU_AND;
      EXT_OR:   alu_of = ALU_OR;
      EXT_XOR:  alu_of = ALU_XOR;
      EXT_NOT:  alu_of = ALU_NOT;
      EXT_ADD:  alu_of = ALU_ADD;
      EXT_ADDU: alu_of = ALU_ADDU;
      EXT_ADDC: alu_of = ALU_ADDC;
      EXT_RSH:  alu_of = ALU_RSH;
      EXT_SUB:  alu_of = ALU_SUB;
      EXT_SUBC: alu_of = ALU_SUBC;
      EXT_CMP:  alu_of = ALU_CMP;
      EXT_LSH:  alu_of = ALU_LSH;
      EXT_MOV:  alu_of = ALU_MOV;
      EXT_MUL:  alu_of = ALU_MUL;
      EXT_ARSH: alu_of = ALU_ARSH;
      default:  alu_of = ALU_NOP;
    endcase
  endfunction

  function automatic logic updates_flags(input alu_op_e op);
    case (op)
      ALU_ADD, ALU_ADDU, ALU_ADDC, ALU_SUB, ALU_SUBC, ALU_MUL, ALU_CMP:
        updates_flags = 1'b1;
      default:
        updates_flags = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] ext_imm(input logic [15:0] instr);
    case (instr[15:12])
      OP_ADDI, OP_ADDCI, OP_SUBI, OP_SUBCI, OP_CMPI, OP_MULI:
        ext_imm = {{8{instr[7]}}, instr[7:0]};
      OP_ADDUI, OP_MOVI, OP_ANDI, OP_ORI, OP_XORI:
        ext_imm = {8'h00, instr[7:0]};
      OP_LSHI, OP_RSHI, OP_ARSHI:
        ext_imm = {12'h000, instr[3:0]};
      default:
        ext_imm = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_queue_if.sv
// Fetch-side instruction handshake plus execute-side decoded-bundle handshake.
interface instr_decode_queue_if
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
);
  logic [15:0]         instr;
  logic                instr_valid;
  logic                instr_ready;
  logic                dec_valid;
  logic                dec_ready;
  alu_op_e             dec_alu_op;
  logic [3:0]          dec_rdest;
  logic [3:0]          dec_rsrc;
  logic [NUM_REGS-1:0] dec_wen;
  logic [DATA_W-1:0]   dec_imm;
  logic                dec_imm_sel;
  logic                dec_flag_en;
  logic                dec_mem_rd;
  logic                dec_mem_wr;
  logic                dec_illegal;

  modport slave (
    input  instr, instr_valid, dec_ready,
    output instr_ready, dec_valid, dec_alu_op, dec_rdest, dec_rsrc, dec_wen,
           dec_imm, dec_imm_sel, dec_flag_en, dec_mem_rd, dec_mem_wr, dec_illegal
  );

  modport master (
    output instr, instr_valid, dec_ready,
    input  instr_ready, dec_valid, dec_alu_op, dec_rdest, dec_rsrc, dec_wen,
           dec_imm, dec_imm_sel, dec_flag_en, dec_mem_rd, dec_mem_wr, dec_illegal
  );
endinterface

// File: rtl/decode_logic.sv
// Combinational instruction -> decoded bundle translation; no state.
module decode_logic
  import decode_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [15:0] instr,
  output dec_bundle_t bundle
);

  dec_bundle_t bundle_s;
  logic        legal_s;
  logic        writes_s;
  logic        reg_oob_s;

  // Classify the opcode, then derive enables; illegal encodings collapse to a NOP
  always_comb begin
    bundle_s       = '0;
    bundle_s.rdest = instr[11:8];
    bundle_s.rsrc  = instr[3:0];
    legal_s        = 1'b1;
    case (instr[15:12])
      OP_REG: begin
        bundle_s.alu_op = alu_of(instr[7:4]);
      end
      OP_MEM: begin
        case (instr[7:4])
          EXT_LOAD: begin
            bundle_s.alu_op = ALU_LOAD;
            bundle_s.mem_rd = 1'b1;
          end
          EXT_STOR: begin
            bundle_s.alu_op = ALU_STOR;
            bundle_s.mem_wr = 1'b1;
          end
          default: legal_s = 1'b0;
        endcase
      end
      default: begin
        bundle_s.alu_op  = alu_of(instr[15:12]);
        bundle_s.imm     = ext_imm(instr);
        bundle_s.imm_sel = 1'b1;
      end
    endcase

    bundle_s.flag_en = updates_flags(bundle_s.alu_op);
    writes_s  = !(bundle_s.alu_op inside {ALU_NOP, ALU_CMP, ALU_STOR});
    reg_oob_s = ({1'b0, instr[11:8]} >= 5'(NUM_REGS));
    legal_s   = legal_s & ~(writes_s & reg_oob_s);

    if (legal_s) begin
      bundle_s.wen = writes_s ? (16'h0001 << instr[11:8]) : 16'h0000;
    end else begin
      bundle_s         = '0;
      bundle_s.rdest   = instr[11:8];
      bundle_s.rsrc    = instr[3:0];
      bundle_s.illegal = 1'b1;
    end
  end

  assign bundle = bundle_s;

endmodule

// File: rtl/instr_decode_queue.sv
// Registered instruction decoder feeding a DEPTH-entry FIFO of decoded bundles.
// Optional illegal-instruction trap: define DECODE_ILLEGAL_TRAP_EN.
module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 2,
  parameter int NUM_REGS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 decode_en,
  instr_decode_queue_if.slave  bus,
  output logic                 illegal_sticky
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  dec_bundle_t      dec_s;
  dec_bundle_t      mem_q [DEPTH];
  dec_bundle_t      mem_d [DEPTH];
  dec_bundle_t      out_q, out_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             run_q;
  logic             trap_s, ready_s, push_s, pop_s;

  decode_logic #(.NUM_REGS(NUM_REGS)) u_decode (
    .instr  (bus.instr),
    .bundle (dec_s)
  );

  assign ready_s = decode_en & run_q & ~trap_s & (count_q < CNT_W'(DEPTH));
  assign push_s  = bus.instr_valid & ready_s;
  assign pop_s   = valid_q & bus.dec_ready;

  // Next FIFO state; the output register reloads whenever the head changes
  // and otherwise keeps the last bundle presented
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = dec_s;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    valid_d = (count_d != '0);
    out_d   = valid_d ? mem_d[rd_ptr_d] : out_q;
  end

  // FIFO storage, pointers and registered head outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      out_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
      run_q    <= 1'b1;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic sticky_q, sticky_d;

  // A dropped push under flush must not arm the trap
  always_comb begin
    if (flush) begin
      sticky_d = 1'b0;
    end else if (push_s && dec_s.illegal) begin
      sticky_d = 1'b1;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Trap latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign trap_s         = sticky_q;
  assign illegal_sticky = sticky_q;
`else
  assign trap_s         = 1'b0;
  assign illegal_sticky = 1'b0;
`endif

  assign bus.instr_ready = ready_s;
  assign bus.dec_valid   = valid_q;
  assign bus.dec_alu_op  = out_q.alu_op;
  assign bus.dec_rdest   = out_q.rdest;
  assign bus.dec_rsrc    = out_q.rsrc;
  assign bus.dec_wen     = out_q.wen[NUM_REGS-1:0];
  assign bus.dec_imm     = DATA_W'($signed(out_q.imm));
  assign bus.dec_imm_sel = out_q.imm_sel;
  assign bus.dec_flag_en = out_q.flag_en;
  assign bus.dec_mem_rd  = out_q.mem_rd;
  assign bus.dec_mem_wr  = out_q.mem_wr;
  assign bus.dec_illegal = out_q.illegal;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed-vector bench for instr_decode_queue (DATA_W=16, DEPTH=2, NUM_REGS=16).
module tb_instr_decode_queue;
  import decode_pkg::*;

  typedef struct {
    logic [15:0] instr;
    alu_op_e     alu;
    logic [15:0] wen;
    logic [15:0] imm;
    logic [4:0]  ctl;   // {imm_sel, flag_en, mem_rd, mem_wr, illegal}
  } vec_t;

  logic clk       = 1'b0;
  logic reset     = 1'b0;
  logic flush     = 1'b0;
  logic decode_en = 1'b0;
  logic illegal_sticky;
  logic [4:0] ctl_s;
  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t vecs [12];

  instr_decode_queue_if #(.DATA_W(16), .NUM_REGS(16)) bus ();

  instr_decode_queue #(.DATA_W(16), .DEPTH(2), .NUM_REGS(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .decode_en      (decode_en),
    .bus            (bus.slave),
    .illegal_sticky (illegal_sticky)
  );

  assign ctl_s = {bus.dec_imm_sel, bus.dec_flag_en, bus.dec_mem_rd, bus.dec_mem_wr, bus.dec_illegal};

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{16'h53FB, ALU_ADD,  16'h0008, 16'hFFFB, 5'b11000};
    vecs[1]  = '{16'h12F0, ALU_AND,  16'h0004, 16'h00F0, 5'b10000};
    vecs[2]  = '{16'hC40F, ALU_LSH,  16'h0010, 16'h000F, 5'b10000};
    vecs[3]  = '{16'h02B5, ALU_CMP,  16'h0000, 16'h0000, 5'b01000};
    vecs[4]  = '{16'h4143, ALU_STOR, 16'h0000, 16'h0000, 5'b00010};
    vecs[5]  = '{16'h4703, ALU_LOAD, 16'h0080, 16'h0000, 5'b00100};
    vecs[6]  = '{16'h0152, ALU_ADD,  16'h0002, 16'h0000, 5'b01000};
    vecs[7]  = '{16'h6A80, ALU_ADDU, 16'h0400, 16'h0080, 5'b11000};
    vecs[8]  = '{16'h9E80, ALU_SUB,  16'h4000, 16'hFF80, 5'b11000};
    vecs[9]  = '{16'hDF7E, ALU_MOV,  16'h8000, 16'h007E, 5'b10000};
    vecs[10] = '{16'h0000, ALU_NOP,  16'h0000, 16'h0000, 5'b00000};
    vecs[11] = '{16'h0D4C, ALU_NOT,  16'h2000, 16'h0000, 5'b00000};

    bus.instr       = 16'h0000;
    bus.instr_valid = 1'b0;
    bus.dec_ready   = 1'b0;
    decode_en       = 1'b1;
    repeat (2) step();
    check_vec("rst_ready",  bus.instr_ready, 32'd0);
    check_vec("rst_valid",  bus.dec_valid,   32'd0);
    check_vec("rst_alu",    bus.dec_alu_op,  32'd0);
    check_vec("rst_wen",    bus.dec_wen,     32'd0);
    check_vec("rst_imm",    bus.dec_imm,     32'd0);
    check_vec("rst_ctl",    ctl_s,           32'd0);
    check_vec("rst_sticky", illegal_sticky,  32'd0);
    reset = 1'b1;
    step();
    check_vec("ready_after_rst", bus.instr_ready, 32'd1);

    // Back-to-back decode stream, one push and one pop per cycle
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.instr       = vecs[i].instr;
      bus.instr_valid = 1'b1;
      step();
      check_vec($sformatf("v%0d_valid", i), bus.dec_valid,  32'd1);
      check_vec($sformatf("v%0d_alu", i),   bus.dec_alu_op, vecs[i].alu);
      check_vec($sformatf("v%0d_wen", i),   bus.dec_wen,    vecs[i].wen);
      check_vec($sformatf("v%0d_imm", i),   bus.dec_imm,    vecs[i].imm);
      check_vec($sformatf("v%0d_ctl", i),   ctl_s,          vecs[i].ctl);
      check_vec($sformatf("v%0d_rdest", i), bus.dec_rdest,  vecs[i].instr[11:8]);
      check_vec($sformatf("v%0d_rsrc", i),  bus.dec_rsrc,   vecs[i].instr[3:0]);
    end
    bus.instr_valid = 1'b0;
    step();
    check_vec("stream_drain", bus.dec_valid, 32'd0);

    // Fill with consumer stalled, then drain in order
    bus.dec_ready   = 1'b0;
    bus.instr       = 16'h5101;
    bus.instr_valid = 1'b1;
    step();
    check_vec("full_rdy1", bus.instr_ready, 32'd1);
    check_vec("full_val1", bus.dec_valid,   32'd1);
    bus.instr = 16'h5202;
    step();
    check_vec("full_rdy2", bus.instr_ready, 32'd0);
    check_vec("full_headA", bus.dec_imm,    32'h0001);
    bus.instr = 16'h5303;
    step();
    check_vec("full_hold", bus.dec_imm,     32'h0001);
    check_vec("full_rdy3", bus.instr_ready, 32'd0);
    bus.dec_ready = 1'b1;
    step();
    check_vec("order_B",     bus.dec_imm,     32'h0002);
    check_vec("order_rdy",   bus.instr_ready, 32'd1);
    step();
    check_vec("order_C",     bus.dec_imm,     32'h0003);
    check_vec("order_C_val", bus.dec_valid,   32'd1);
    bus.instr_valid = 1'b0;
    step();
    check_vec("order_empty", bus.dec_valid,   32'd0);
    check_vec("empty_hold",  bus.dec_imm,     32'h0003);

    // Flush while full with a pending instruction
    bus.dec_ready   = 1'b0;
    bus.instr       = 16'h5404;
    bus.instr_valid = 1'b1;
    step();
    bus.instr = 16'h5505;
    step();
    check_vec("flush_pre_rdy", bus.instr_ready, 32'd0);
    flush     = 1'b1;
    bus.instr = 16'h5606;
    step();
    check_vec("flush_valid", bus.dec_valid,   32'd0);
    check_vec("flush_rdy",   bus.instr_ready, 32'd1);
    check_vec("flush_hold",  bus.dec_imm,     32'h0004);
    step();
    check_vec("flush_push_drop", bus.dec_valid, 32'd0);
    flush           = 1'b0;
    bus.instr_valid = 1'b0;
    step();
    check_vec("flush_after", bus.dec_valid, 32'd0);

    // decode_en low blocks acceptance
    decode_en       = 1'b0;
    bus.instr       = 16'h5808;
    bus.instr_valid = 1'b1;
    #1;
    check_vec("den_ready", bus.instr_ready, 32'd0);
    step();
    check_vec("den_valid", bus.dec_valid, 32'd0);
    decode_en       = 1'b1;
    bus.instr_valid = 1'b0;
    step();

    // Illegal memory sub-op
    bus.dec_ready   = 1'b1;
    bus.instr       = 16'h4020;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    check_vec("ill_valid", bus.dec_valid,  32'd1);
    check_vec("ill_ctl",   ctl_s,          32'h01);
    check_vec("ill_wen",   bus.dec_wen,    32'd0);
    check_vec("ill_alu",   bus.dec_alu_op, 32'd0);
    check_vec("ill_imm",   bus.dec_imm,    32'd0);
    step();
    check_vec("ill_drained", bus.dec_valid, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check_vec("trap_sticky", illegal_sticky,  32'd1);
    check_vec("trap_ready",  bus.instr_ready, 32'd0);
    bus.instr       = 16'h5909;
    bus.instr_valid = 1'b1;
    step();
    check_vec("trap_block", bus.dec_valid, 32'd0);
    flush = 1'b1;
    step();
    flush           = 1'b0;
    bus.instr_valid = 1'b0;
    #1;
    check_vec("trap_clr",       illegal_sticky,  32'd0);
    check_vec("trap_clr_ready", bus.instr_ready, 32'd1);
`else
    check_vec("no_trap_sticky", illegal_sticky,  32'd0);
    check_vec("no_trap_ready",  bus.instr_ready, 32'd1);
`endif

    // Asynchronous reset with bundles queued
    bus.dec_ready   = 1'b0;
    bus.instr       = 16'h5A0A;
    bus.instr_valid = 1'b1;
    step();
    bus.instr = 16'h5B0B;
    step();
    bus.instr_valid = 1'b0;
    check_vec("mid_pre_valid", bus.dec_valid, 32'd1);
    reset = 1'b0;
    #1;
    check_vec("mid_valid",  bus.dec_valid,   32'd0);
    check_vec("mid_imm",    bus.dec_imm,     32'd0);
    check_vec("mid_wen",    bus.dec_wen,     32'd0);
    check_vec("mid_alu",    bus.dec_alu_op,  32'd0);
    check_vec("mid_ctl",    ctl_s,           32'd0);
    check_vec("mid_rdest",  bus.dec_rdest,   32'd0);
    check_vec("mid_ready",  bus.instr_ready, 32'd0);
    check_vec("mid_sticky", illegal_sticky,  32'd0);
    step();
    reset = 1'b1;
    step();
    step();
    check_vec("post_valid", bus.dec_valid,   32'd0);
    check_vec("post_ready", bus.instr_ready, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Parametrised, registered successor to the combinational instruction decoder.
- Accepts 16-bit instructions over a valid/ready handshake and fully decodes each one into a control bundle: ALU op, register addresses, one-hot write enable, extended immediate, memory and flag controls, illegal flag.
- Buffers decoded bundles in a DEPTH-entry FIFO so fetch and execute decouple.
- Sits between the instruction fetch/PC stage and the register-file/ALU datapath.

Parameters:
- DATA_W, 16: datapath width; immediate is extended to DATA_W. Must be >= 16.
- DEPTH, 2: decoded-bundle FIFO entries. Power of two, >= 2.
- NUM_REGS, 16: register count; width of the one-hot write enable. Must be <= 16 (4-bit register fields).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous FIFO clear (branch/jump redirect).
- decode_en  in  1  active-high; when low, no instruction is accepted.
- instr  in  16  instruction word.
- instr_valid  in  1  instr is valid.
- instr_ready  out  1  block can accept instr this cycle.
- dec_valid  out  1  FIFO head holds a valid bundle.
- dec_ready  in  1  consumer takes the head this cycle.
- dec_alu_op  out  5  ALU operation code (package enum).
- dec_rdest  out  4  instr[11:8].
- dec_rsrc  out  4  instr[3:0].
- dec_wen  out  NUM_REGS  one-hot register write enable.
- dec_imm  out  DATA_W  extended immediate.
- dec_imm_sel  out  1  ALU B operand is dec_imm.
- dec_flag_en  out  1  PSR flags update.
- dec_mem_rd  out  1  LOAD.
- dec_mem_wr  out  1  STOR.
- dec_illegal  out  1  encoding not recognised.
- illegal_sticky  out  1  trap latched (feature only; otherwise tied 0).

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO pointers and count go to 0.
  - dec_valid = 0; all dec_* outputs = 0; illegal_sticky = 0.
  - instr_ready = 0 while reset is asserted.
- Field extraction: op = instr[15:12], ext = instr[7:4].
- Register ops (op = 0000), selected by ext:
  - 0101 ADD, 0110 ADDU, 0111 ADDC, 1001 SUB, 1010 SUBC, 1011 CMP, 1110 MUL.
  - 0001 AND, 0010 OR, 0011 XOR, 0100 NOT, 1101 MOV.
  - 1100 LSH, 1000 RSH, 1111 ARSH.
  - 0000 WAIT: NOP, dec_wen = 0.
- Immediate ops, selected by op:
  - 0101 ADDI, 0110 ADDUI, 0111 ADDCI, 1001 SUBI, 1010 SUBCI, 1011 CMPI, 1101 MOVI, 1110 MULI.
  - 0001 ANDI, 0010 ORI, 0011 XORI.
  - 1100 LSHI, 1000 RSHI, 1111 ARSHI.
- Memory ops (op = 0100): ext 0000 = LOAD, ext 0100 = STOR; any other ext is illegal.
- Immediate extension:
  - Sign-extend instr[7:0] to DATA_W: ADDI, ADDCI, SUBI, SUBCI, CMPI, MULI.
  - Zero-extend instr[7:0]: ADDUI, MOVI, ANDI, ORI, XORI.
  - Zero-extend instr[3:0]: LSHI, RSHI, ARSHI.
  - dec_imm = 0 for all non-immediate ops.
- dec_wen:
  - One-hot of rdest for ops that write a register.
  - 0 for CMP, CMPI, STOR, WAIT and illegal encodings.
  - 0 if rdest >= NUM_REGS; that case also sets dec_illegal = 1.
- dec_flag_en = 1 for arithmetic, CMP and CMPI only.
- Illegal encoding: bundle is a NOP (all enables 0) with dec_illegal = 1.
- Handshakes:
  - instr_ready = decode_en && (count < DEPTH).
  - Push when instr_valid && instr_ready. Pop when dec_valid && dec_ready.
  - Push and pop in the same cycle leave count unchanged.
  - No combinational path from instr to dec_* outputs.
- Latency: 1 cycle from accepting push to dec_valid (when the FIFO was empty). Throughput: 1 instruction per cycle.
- Full: instr_ready = 0; a pop frees a slot, and the next push is accepted the following cycle.
- Empty: dec_valid = 0; the dec_* outputs hold their last values and must not be used.
- flush: next cycle count = 0 and dec_valid = 0. flush takes priority over a same-cycle push and pop; that push is dropped.
- Pointer wrap: modulo DEPTH.
- Reset mid-operation: all queued bundles are discarded.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Pushing an illegal bundle sets illegal_sticky.
  - While illegal_sticky = 1, instr_ready = 0; bundles already queued still drain.
  - illegal_sticky clears only on reset or flush.
- Undefined: illegal_sticky is tied 0; illegal bundles flow as NOPs with dec_illegal = 1.

Decomposition:
- Package decode_pkg:
  - ALU op enum (5-bit).
  - op and ext localparams.
  - Decoded bundle struct (all dec_* fields).
  - function ext_imm.
- Sub-module decode_logic: purely combinational instr -> bundle.
- The top level holds the FIFO, handshake and trap logic.

Test Plan:
- ADDI 0x5_3_FB (instr 16'h53FB), empty FIFO, dec_ready = 1 -> next cycle: dec_valid = 1, dec_alu_op = ADD, dec_imm = 16'hFFFB, dec_imm_sel = 1, dec_wen = 16'h0008, dec_flag_en = 1.
- ANDI 16'h12F0 then LSHI 16'hC40F -> dec_imm = 16'h00F0, then 16'h000F; both dec_wen one-hot and dec_flag_en = 0.
- CMP 16'h02B5 and STOR 16'h4143 -> dec_wen = 0. CMP: dec_flag_en = 1. STOR: dec_mem_wr = 1, dec_mem_rd = 0.
- Hold dec_ready = 0 with DEPTH = 2 and push 3 instructions -> instr_ready falls after the 2nd push. Raise dec_ready -> FIFO order preserved, 1 pop per cycle.
- Assert flush while full and instr_valid = 1 -> next cycle dec_valid = 0, count = 0, the same-cycle instruction is not queued.
- Push illegal 16'h4020 -> dec_illegal = 1, all enables 0. With DECODE_ILLEGAL_TRAP_EN: illegal_sticky = 1 and instr_ready = 0 until flush; assert reset low mid-stream -> all outputs 0 immediately.
